// File: rtl/sync_filter_pkg.sv
// Shared constants and helpers for the sync_filter input conditioner.
//   SYNC_MIN_STAGES / SYNC_MAX_STAGES : legal synchronizer depth range
//   SYNC_MAX_FILTER                   : largest legal glitch-filter length
//   cnt_width()                       : width of the per-channel filter counter
package sync_pkg;

    localparam int unsigned SYNC_MIN_STAGES = 2;
    localparam int unsigned SYNC_MAX_STAGES = 4;
    localparam int unsigned SYNC_MAX_FILTER = 15;

    // clog2(filter_len+1); never below 1 so a declaration stays legal when
    // the filter is bypassed (the counter is not generated in that case).
    function automatic int unsigned cnt_width(input int unsigned filter_len);
        int unsigned w;
        w = $clog2(filter_len + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_filter_glitch_filter.sv
// Single-channel glitch filter and edge detector.
//   clk, reset : clock, asynchronous active-high reset
//   sync       : synchronized channel level
//   data_out   : filtered level (sync itself when FILTER_LEN == 0)
//   rise/fall  : one-cycle pulses when data_out changes 0->1 / 1->0
module sync_glitch_filter
    import sync_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 3,
    parameter logic        RESET_VAL  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic sync,
    output logic data_out,
    output logic rise,
    output logic fall
);

    logic level;
    logic prev;

    if (FILTER_LEN == 0) begin : g_bypass
        assign level = sync;
    end else begin : g_filter
        localparam int unsigned     CW       = cnt_width(FILTER_LEN);
        localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_LEN - 1);

        logic          filt;
        logic [CW-1:0] cnt;

        // cnt counts consecutive samples disagreeing with filt; any agreeing
        // sample restarts the count, so short pulses never reach filt.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                filt <= RESET_VAL;
                cnt  <= '0;
            end else if (sync == filt) begin
                cnt  <= '0;
            end else if (cnt == CNT_LAST) begin
                filt <= sync;
                cnt  <= '0;
            end else begin
                cnt  <= cnt + CW'(1);
            end
        end

        assign level = filt;
    end

    // prev resets to the same value as the level, so no pulse on reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev <= RESET_VAL;
        else       prev <= level;
    end

    assign data_out = level;
    assign rise     = level & ~prev;
    assign fall     = ~level & prev;

endmodule

// File: rtl/sync_filter.sv
// Multi-channel input conditioner: per-channel STAGES-deep synchronizer
// followed by an optional consecutive-sample glitch filter and edge detect.
// Channels are independent; not for multi-bit buses needing coherence.
//   clk, reset : clock, asynchronous active-high reset
//   data_in    : asynchronous channel inputs
//   data_out   : synchronized, filtered levels
//   rise/fall  : one-cycle pulses on data_out 0->1 / 1->0
module sync_filter
    import sync_pkg::*;
#(
    parameter int unsigned          WIDTH      = 1,
    parameter int unsigned          STAGES     = 2,
    parameter int unsigned          FILTER_LEN = 3,
    parameter logic [WIDTH-1:0]     RESET_VAL  = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    if (STAGES < SYNC_MIN_STAGES || STAGES > SYNC_MAX_STAGES) begin : g_bad_stages
        $error("sync_filter: STAGES out of range 2..4");
    end
    if (FILTER_LEN > SYNC_MAX_FILTER) begin : g_bad_filter
        $error("sync_filter: FILTER_LEN out of range 0..15");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("sync_filter: WIDTH must be at least 1");
    end

    logic [WIDTH-1:0] sync;

    for (genvar i = 0; i < WIDTH; i++) begin : g_sync
        logic [STAGES-1:0] chain;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) chain <= {STAGES{RESET_VAL[i]}};
            else       chain <= {chain[STAGES-2:0], data_in[i]};
        end

        assign sync[i] = chain[STAGES-1];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sync_glitch_filter #(
            .FILTER_LEN (FILTER_LEN),
            .RESET_VAL  (RESET_VAL[i])
        ) u_filter (
            .clk      (clk),
            .reset    (reset),
            .sync     (sync[i]),
            .data_out (data_out[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

endmodule

// File: tb/tb_sync_filter.sv
// Self-checking bench for sync_filter. Three instances:
//   u_a : WIDTH=4, STAGES=2, FILTER_LEN=3, RESET_VAL=4'hF
//   u_b : WIDTH=1, STAGES=2, FILTER_LEN=0 (bypass), driven by data_in[0]
//   u_c : WIDTH=4, STAGES=3, FILTER_LEN=4, RESET_VAL=4'b1010
// A window-based model predicts every output each cycle; directed windows
// pin latencies, pulse widths and glitch rejection with literal values.
module tb_sync_filter;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] din   = 4'h0;

    logic [3:0] a_out, a_rise, a_fall;
    logic       b_out, b_rise, b_fall;
    logic [3:0] c_out, c_rise, c_fall;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    always #5 clk = ~clk;

    sync_filter #(.WIDTH(4), .STAGES(2), .FILTER_LEN(3), .RESET_VAL(4'hF)) u_a (
        .clk(clk), .reset(reset), .data_in(din),
        .data_out(a_out), .rise(a_rise), .fall(a_fall));

    sync_filter #(.WIDTH(1), .STAGES(2), .FILTER_LEN(0), .RESET_VAL(1'b1)) u_b (
        .clk(clk), .reset(reset), .data_in(din[0]),
        .data_out(b_out), .rise(b_rise), .fall(b_fall));

    sync_filter #(.WIDTH(4), .STAGES(3), .FILTER_LEN(4), .RESET_VAL(4'b1010)) u_c (
        .clk(clk), .reset(reset), .data_in(din),
        .data_out(c_out), .rise(c_rise), .fall(c_fall));

    function automatic int st_of(input int m);
        return (m == 2) ? 3 : 2;
    endfunction
    function automatic int fl_of(input int m);
        return (m == 0) ? 3 : (m == 1) ? 0 : 4;
    endfunction
    function automatic logic [3:0] rv_of(input int m);
        return (m == 2) ? 4'b1010 : 4'hF;
    endfunction
    function automatic logic [3:0] mask_of(input int m);
        return (m == 1) ? 4'b0001 : 4'b1111;
    endfunction

    function automatic logic [3:0] outs(input int m);
        return (m == 0) ? a_out : (m == 1) ? {3'b000, b_out} : c_out;
    endfunction
    function automatic logic [3:0] rises(input int m);
        return (m == 0) ? a_rise : (m == 1) ? {3'b000, b_rise} : c_rise;
    endfunction
    function automatic logic [3:0] falls(input int m);
        return (m == 0) ? a_fall : (m == 1) ? {3'b000, b_fall} : c_fall;
    endfunction

    // Model: data_in samples delayed by STAGES edges give the synchronized
    // level; the filtered level flips once the last FILTER_LEN pre-edge
    // synchronized samples all disagree with it.
    bit   [15:0] dh [3][4];
    bit   [15:0] sh [3][4];
    logic [3:0]  mo [3];
    logic [3:0]  mp [3];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int m = 0; m < 3; m++) begin
                logic [3:0] r;
                r = rv_of(m);
                mo[m] = r;
                mp[m] = r;
                for (int c = 0; c < 4; c++) begin
                    dh[m][c] = {16{r[c]}};
                    sh[m][c] = {16{r[c]}};
                end
            end
        end else begin
            for (int m = 0; m < 3; m++) begin
                int st, fl;
                st = st_of(m);
                fl = fl_of(m);
                mp[m] = mo[m];
                for (int c = 0; c < 4; c++) begin
                    bit all_diff;
                    sh[m][c] = {sh[m][c][14:0], dh[m][c][st-1]};
                    dh[m][c] = {dh[m][c][14:0], din[c]};
                    if (fl == 0) begin
                        mo[m][c] = dh[m][c][st-1];
                    end else begin
                        all_diff = 1'b1;
                        for (int k = 0; k < fl; k++)
                            if (sh[m][c][k] == mo[m][c]) all_diff = 1'b0;
                        if (all_diff) mo[m][c] = ~mo[m][c];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            for (int m = 0; m < 3; m++) begin
                logic [3:0] mk, eo, er, ef;
                mk = mask_of(m);
                eo = mo[m];
                er = mo[m] & ~mp[m];
                ef = ~mo[m] & mp[m];
                checks++;
                if (((outs(m) & mk) !== (eo & mk)) || ((rises(m) & mk) !== (er & mk)) ||
                    ((falls(m) & mk) !== (ef & mk))) begin
                    errors++;
                    $display("FAIL model_cmp inst=%0d t=%0t out=%b rise=%b fall=%b required out=%b rise=%b fall=%b",
                             m, $time, outs(m) & mk, rises(m) & mk, falls(m) & mk,
                             eo & mk, er & mk, ef & mk);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Directed windows: stim entries are applied one per cycle just after the
    // active edge; each tick t corresponds to edge t after the window start.
    logic [3:0] stim[$];
    int fch [3][4];
    int lowc[3][4];
    int rc  [3][4];
    int fc  [3][4];

    task automatic window(input int n);
        logic [3:0] st0[3];
        logic [3:0] o, r, f;
        for (int m = 0; m < 3; m++) begin
            st0[m] = outs(m);
            for (int c = 0; c < 4; c++) begin
                fch[m][c] = -1; lowc[m][c] = 0; rc[m][c] = 0; fc[m][c] = 0;
            end
        end
        for (int t = 1; t <= n; t++) begin
            if (stim.size() > 0) din = stim.pop_front();
            @(posedge clk); #1;
            for (int m = 0; m < 3; m++) begin
                o = outs(m); r = rises(m); f = falls(m);
                for (int c = 0; c < 4; c++) begin
                    if (fch[m][c] < 0 && o[c] != st0[m][c]) fch[m][c] = t;
                    if (!o[c]) lowc[m][c]++;
                    if (r[c])  rc[m][c]++;
                    if (f[c])  fc[m][c]++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        #2 reset = 1'b1;
        run_cmp = 1'b1;
        repeat (3) tick();

        chk("reset_a_out",  int'(a_out), 15, 15);
        chk("reset_a_rise", int'(a_rise), 0, 0);
        chk("reset_a_fall", int'(a_fall), 0, 0);
        chk("reset_b_out",  int'(b_out), 1, 1);
        chk("reset_c_out",  int'(c_out), 10, 10);

        // Release with data_in still 0.
        reset = 1'b0;
        window(12);
        chk("rel_a_latency", fch[0][0], 5, 6);
        chk("rel_a_fall",    fc[0][0], 1, 1);
        chk("rel_a_rise",    rc[0][0], 0, 0);
        chk("rel_b_latency", fch[1][0], 2, 3);
        chk("rel_c3_latency", fch[2][3], 7, 8);
        chk("rel_c0_rise",   rc[2][0], 0, 0);

        stim.push_back(4'hF);
        window(12);
        chk("up_a_latency", fch[0][0], 5, 6);
        chk("up_a_rise",    rc[0][0], 1, 1);
        chk("up_c0_latency", fch[2][0], 7, 8);

        // Steady 1 -> 0.
        stim.push_back(4'h0);
        window(12);
        chk("down_a_latency", fch[0][1], 5, 6);
        chk("down_a_fall",    fc[0][1], 1, 1);
        chk("down_a_rise",    rc[0][1], 0, 0);
        chk("down_b_latency", fch[1][0], 2, 3);
        stim.push_back(4'hF);
        window(12);

        // Two-cycle low glitch is rejected by FILTER_LEN=3, passed by bypass.
        stim = '{4'hE, 4'hE, 4'hF};
        window(12);
        chk("glitch2_a_low",  lowc[0][0], 0, 0);
        chk("glitch2_a_fall", fc[0][0], 0, 0);
        chk("glitch2_b_low",  lowc[1][0], 2, 2);

        // Three-cycle low passes FILTER_LEN=3 with width preserved.
        stim = '{4'hE, 4'hE, 4'hE, 4'hF};
        window(14);
        chk("glitch3_a_low",  lowc[0][0], 3, 3);
        chk("glitch3_a_fall", fc[0][0], 1, 1);
        chk("glitch3_a_rise", rc[0][0], 1, 1);
        chk("glitch3_c_low",  lowc[2][0], 0, 0);

        // Alternating every cycle.
        for (int i = 0; i < 20; i++) stim.push_back((i % 2 == 0) ? 4'hE : 4'hF);
        stim.push_back(4'hF);
        window(26);
        chk("toggle_a_low", lowc[0][0], 0, 0);
        chk("toggle_c_low", lowc[2][0], 0, 0);
        chk("toggle_b_low", lowc[1][0], 10, 10);

        // Reset mid-count on u_c (FILTER_LEN=4): two mismatching samples counted.
        stim.push_back(4'h0);
        window(5);
        reset = 1'b1;
        #1;
        chk("midrst_c_out",  int'(c_out), 10, 10);
        chk("midrst_c_rise", int'(c_rise), 0, 0);
        chk("midrst_c_fall", int'(c_fall), 0, 0);
        chk("midrst_a_out",  int'(a_out), 15, 15);
        tick();
        reset = 1'b0;
        window(12);
        chk("midrst_c3_latency", fch[2][3], 7, 8);
        chk("midrst_c1_latency", fch[2][1], 7, 8);
        chk("midrst_a0_latency", fch[0][0], 5, 6);
        stim.push_back(4'hF);
        window(12);

        // Per-channel low pulses of 1, 2, 3 and 5 cycles.
        stim = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b0111, 4'b1111};
        window(16);
        chk("multi_a0_low", lowc[0][0], 0, 0);
        chk("multi_a1_low", lowc[0][1], 0, 0);
        chk("multi_a2_low", lowc[0][2], 3, 3);
        chk("multi_a3_low", lowc[0][3], 5, 5);
        chk("multi_a2_fall", fc[0][2], 1, 1);
        chk("multi_a3_rise", rc[0][3], 1, 1);
        chk("multi_c2_low", lowc[2][2], 0, 0);
        chk("multi_c3_low", lowc[2][3], 5, 5);
        chk("multi_b_low",  lowc[1][0], 1, 1);

        // Random levels held long enough for every filter length in use.
        for (int i = 0; i < 40; i++) begin
            logic [3:0] v;
            int h;
            v = 4'($urandom_range(0, 15));
            h = $urandom_range(5, 8);
            for (int j = 0; j < h; j++) stim.push_back(v);
            window(h);
        end
        stim.push_back(4'hF);
        window(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation did not complete by %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
